ex_alu_seq: RTL and testbench

EX_ALU_SEQ -- requirements
Module: ex_alu_seq

---
 rtl/ex_alu_seq_if.sv | 29 ++
 rtl/ex_alu_seq.sv | 179 +++++++++++++++++
 tb/tb_ex_alu_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_alu_seq_if.sv
// Request/response bundle for ex_alu_seq.
// master: the side that issues operations and consumes results.
// slave:  the ALU.
interface ex_alu_seq_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      aluOp;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, aluOp, funct7, funct3, a, b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, aluOp, funct7, funct3, a, b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/ex_alu_seq.sv
// ex_alu_seq: RV64-style execute ALU with a valid/ready request side and a
// registered, held result side. Single-cycle ops complete in one clock.
// Optional feature macro EX_ALU_MUL_EN adds a radix-2 shift-add multiplier
// (funct7=0000001, funct3=000) that takes exactly XLEN cycles in state MUL.
// Without the macro there is no MUL datapath and busy is tied low.
module ex_alu_seq #(
  parameter int XLEN = 64,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic         clk,
  input  logic         reset,
  ex_alu_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL
  } op_t;

  state_t                 state;
  op_t                    op_p0;
  logic signed [XLEN-1:0] a_p0;
  logic signed [XLEN-1:0] b_p0;
  logic        [XLEN-1:0] alu_res_p0;
  logic                   accept;
  logic                   out_valid_q;
  logic        [XLEN-1:0] result_q;
  logic                   zero_q;

  // Single-cycle operations; shifts only honour the low SHW bits of b.
  function automatic logic [XLEN-1:0] alu_fn(input op_t op,
                                             input logic signed [XLEN-1:0] x,
                                             input logic signed [XLEN-1:0] y);
    logic [SHW-1:0] sh;
    sh = y[SHW-1:0];
    case (op)
      OP_SUB:  return x - y;
      OP_SLL:  return x << sh;
      OP_SLT:  return {{(XLEN-1){1'b0}}, (x < y)};
      OP_SLTU: return {{(XLEN-1){1'b0}}, ($unsigned(x) < $unsigned(y))};
      OP_XOR:  return x ^ y;
      OP_SRL:  return $unsigned(x) >> sh;
      OP_SRA:  return x >>> sh;
      OP_OR:   return x | y;
      OP_AND:  return x & y;
      default: return x + y;
    endcase
  endfunction

  assign a_p0 = bus.a;
  assign b_p0 = bus.b;

  // Decode aluOp/funct7/funct3 into an operation; anything unlisted is add.
  always_comb begin
    op_p0 = OP_ADD;
    case (bus.aluOp)
      2'b01: op_p0 = OP_SUB;
      2'b10: begin
        case (bus.funct7)
          7'b0000000: begin
            case (bus.funct3)
              3'b001:  op_p0 = OP_SLL;
              3'b010:  op_p0 = OP_SLT;
              3'b011:  op_p0 = OP_SLTU;
              3'b100:  op_p0 = OP_XOR;
              3'b101:  op_p0 = OP_SRL;
              3'b110:  op_p0 = OP_OR;
              3'b111:  op_p0 = OP_AND;
              default: op_p0 = OP_ADD;
            endcase
          end
          7'b0100000: begin
            if (bus.funct3 == 3'b000)      op_p0 = OP_SUB;
            else if (bus.funct3 == 3'b101) op_p0 = OP_SRA;
          end
`ifdef EX_ALU_MUL_EN
          7'b0000001: if (bus.funct3 == 3'b000) op_p0 = OP_MUL;
`endif
          default: op_p0 = OP_ADD;
        endcase
      end
      default: op_p0 = OP_ADD;
    endcase
  end

  assign alu_res_p0 = alu_fn(op_p0, a_p0, b_p0);

  // A HOLD slot frees up in the same cycle the consumer takes the result.
  assign bus.in_ready = (state == IDLE) || ((state == HOLD) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef EX_ALU_MUL_EN
  logic            is_mul;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] acc_p1;
  logic [XLEN-1:0] mcand_p1;
  logic [XLEN-1:0] mplier_p1;
  logic [XLEN-1:0] mul_next_p1;

  assign is_mul      = (op_p0 == OP_MUL);
  assign mul_next_p1 = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);
  assign bus.busy    = (state == MUL);

  // ---- stage p1: shift-add multiplier, one multiplier bit per clock ----
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      acc_p1    <= '0;
      mcand_p1  <= bus.a;
      mplier_p1 <= bus.b;
    end else if (state == MUL) begin
      acc_p1    <= mul_next_p1;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end
`else
  assign bus.busy = 1'b0;
`endif

  // ---- output stage: control FSM with registered result/zero/out_valid ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
`ifdef EX_ALU_MUL_EN
      cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
`ifdef EX_ALU_MUL_EN
            if (is_mul) begin
              state       <= MUL;
              out_valid_q <= 1'b0;
              cnt         <= '0;
            end else
`endif
            begin
              state       <= HOLD;
              out_valid_q <= 1'b1;
              result_q    <= alu_res_p0;
              zero_q      <= (alu_res_p0 == '0);
            end
          end else if ((state == HOLD) && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
`ifdef EX_ALU_MUL_EN
        MUL: begin
          if (cnt == SHW'(XLEN - 1)) begin
            state       <= HOLD;
            out_valid_q <= 1'b1;
            result_q    <= mul_next_p1;
            zero_q      <= (mul_next_p1 == '0);
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_ex_alu_seq.sv
// Directed testbench for ex_alu_seq (XLEN=64). Mul scenarios are compiled
// in when EX_ALU_MUL_EN is defined; otherwise funct7=0000001 is checked as add.
module tb_ex_alu_seq;
  localparam int XLEN = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  ex_alu_seq_if #(.XLEN(XLEN)) bus ();

  ex_alu_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [1:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    bus.in_valid = v;
    bus.aluOp    = op;
    bus.funct7   = f7;
    bus.funct3   = f3;
    bus.a        = a;
    bus.b        = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, 2'b00, 7'h00, 3'b000, 64'd0, 64'd0);
    step();
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", bus.zero); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    reset = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    step();
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b00, 7'h00, 3'b000, 64'd5, 64'd7);
    step();
    drive(1'b0, 2'b00, 7'h00, 3'b000, 64'd0, 64'd0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.result !== 64'd12) begin errors++; $display("FAIL add_result: got %h want %h", bus.result, 64'd12); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL add_zero: got %b want 0", bus.zero); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_release: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    vec_t v[18];
    v[0]  = '{2'b10, 7'h00, 3'b000, 64'd100, 64'd23, 64'd123};
    v[1]  = '{2'b10, 7'h00, 3'b001, 64'd1, 64'd65, 64'd2};
    v[2]  = '{2'b10, 7'h00, 3'b010, ONES, 64'd1, 64'd1};
    v[3]  = '{2'b10, 7'h00, 3'b010, 64'd1, ONES, 64'd0};
    v[4]  = '{2'b10, 7'h00, 3'b011, ONES, 64'd1, 64'd0};
    v[5]  = '{2'b10, 7'h00, 3'b011, 64'd1, ONES, 64'd1};
    v[6]  = '{2'b10, 7'h00, 3'b100, 64'hF0F0, 64'hFF00, 64'h0FF0};
    v[7]  = '{2'b10, 7'h00, 3'b101, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000};
    v[8]  = '{2'b10, 7'h00, 3'b110, 64'hF0, 64'h0F, 64'hFF};
    v[9]  = '{2'b10, 7'h00, 3'b111, 64'hF0, 64'h3C, 64'h30};
    v[10] = '{2'b10, 7'h20, 3'b000, 64'd0, 64'd1, ONES};
    v[11] = '{2'b10, 7'h20, 3'b101, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000};
    v[12] = '{2'b10, 7'h20, 3'b101, 64'h8000_0000_0000_0000, 64'h104, 64'hF800_0000_0000_0000};
    v[13] = '{2'b10, 7'h20, 3'b001, 64'd2, 64'd3, 64'd5};
    v[14] = '{2'b10, 7'h7F, 3'b111, 64'd2, 64'd3, 64'd5};
    v[15] = '{2'b11, 7'h00, 3'b001, ONES, 64'd1, 64'd0};
    v[16] = '{2'b01, 7'h00, 3'b000, 64'h1234, 64'h1234, 64'd0};
    v[17] = '{2'b10, 7'h01, 3'b011, 64'd3, 64'd4, 64'd7};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, v[i].op, v[i].f7, v[i].f3, v[i].a, v[i].b);
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.out_valid); end
      checks++; if (bus.result !== v[i].exp) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, bus.result, v[i].exp); end
      checks++; if (bus.zero !== (v[i].exp == 64'd0)) begin errors++; $display("FAIL b2b_zero[%0d]: got %b want %b", i, bus.zero, (v[i].exp == 64'd0)); end
    end
    drive(1'b0, 2'b00, 7'h00, 3'b000, 64'd0, 64'd0);
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_hold();
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 7'h00, 3'b000, 64'd10, 64'd20);
    step();
    drive(1'b1, 2'b00, 7'h00, 3'b000, 64'd1, 64'd1);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.result !== 64'd30) begin errors++; $display("FAIL hold_result[%0d]: got %h want %h", i, bus.result, 64'd30); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", i, bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b want 1", bus.in_ready); end
    step();
    drive(1'b0, 2'b00, 7'h00, 3'b000, 64'd0, 64'd0);
    checks++; if (bus.result !== 64'd2) begin errors++; $display("FAIL hold_queued_result: got %h want %h", bus.result, 64'd2); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_no_bubble: got %b want 1", bus.out_valid); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_idle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 7'h00, 3'b000, 64'd40, 64'd2);
    step();
    drive(1'b0, 2'b00, 7'h00, 3'b000, 64'd0, 64'd0);
    checks++; if (bus.result !== 64'd42) begin errors++; $display("FAIL areset_pre: got %h want %h", bus.result, 64'd42); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL areset_result: got %h want 0", bus.result); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL areset_zero: got %b want 1", bus.zero); end
    #1 reset = 1'b0;
    step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready: got %b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
  endtask

`ifdef EX_ALU_MUL_EN
  task automatic test_mul();
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b10, 7'h01, 3'b000, 64'd3, ONES);
    step();
    drive(1'b1, 2'b00, 7'h00, 3'b000, 64'd9, 64'd9);
    for (int i = 0; i < 64; i++) begin
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mul_busy[%0d]: got %b want 1", i, bus.busy); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mul_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mul_valid[%0d]: got %b want 0", i, bus.out_valid); end
      step();
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_done_busy: got %b want 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mul_done_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.result !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL mul_result: got %h want %h", bus.result, 64'hFFFF_FFFF_FFFF_FFFD); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL mul_zero: got %b want 0", bus.zero); end
    drive(1'b1, 2'b10, 7'h01, 3'b000, 64'd6, 64'd7);
    step();
    drive(1'b0, 2'b00, 7'h00, 3'b000, 64'd0, 64'd0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mul_b2b_drop: got %b want 0", bus.out_valid); end
    for (int i = 0; i < 64; i++) step();
    checks++; if (bus.result !== 64'd42) begin errors++; $display("FAIL mul_b2b_result: got %h want %h", bus.result, 64'd42); end
    step();
    drive(1'b1, 2'b10, 7'h01, 3'b001, 64'd3, 64'd4);
    step();
    drive(1'b0, 2'b00, 7'h00, 3'b000, 64'd0, 64'd0);
    checks++; if (bus.result !== 64'd7) begin errors++; $display("FAIL mulx_add: got %h want %h", bus.result, 64'd7); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mulx_busy: got %b want 0", bus.busy); end
    step();
  endtask

  task automatic test_reset_mid_mul();
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b10, 7'h01, 3'b000, 64'd3, 64'd5);
    step();
    drive(1'b0, 2'b00, 7'h00, 3'b000, 64'd0, 64'd0);
    for (int i = 0; i < 30; i++) step();
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mreset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL mreset_result: got %h want 0", bus.result); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL mreset_zero: got %b want 1", bus.zero); end
    step();
    reset = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mreset_in_ready: got %b want 1", bus.in_ready); end
    for (int i = 0; i < 70; i++) begin
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mreset_late[%0d]: got %b want 0", i, bus.out_valid); end
    end
    checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL mreset_final: got %h want 0", bus.result); end
  endtask
`else
  task automatic test_mul_disabled();
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b10, 7'h01, 3'b000, 64'd3, 64'd4);
    step();
    drive(1'b0, 2'b00, 7'h00, 3'b000, 64'd0, 64'd0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL nomul_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.result !== 64'd7) begin errors++; $display("FAIL nomul_result: got %h want %h", bus.result, 64'd7); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nomul_busy: got %b want 0", bus.busy); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_hold();
    test_async_reset();
`ifdef EX_ALU_MUL_EN
    test_mul();
    test_reset_mid_mul();
`else
    test_mul_disabled();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
